// File: rtl/axis_window_shifter.sv
`default_nettype none
// ============================================================================
// axis_window_shifter : shadowed window hit test feeding a small FWFT pixel FIFO
// Revision 1.0 - initial release
// ============================================================================
module axis_window_shifter #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12,
    parameter int C_FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_start,
    input  logic [C_IMG_WBITS-1:0]           col_idx,
    input  logic [C_IMG_HBITS-1:0]           row_idx,
    input  logic [C_IMG_WBITS-1:0]           s_win_left,
    input  logic [C_IMG_WBITS-1:0]           s_win_width,
    input  logic [C_IMG_HBITS-1:0]           s_win_top,
    input  logic [C_IMG_HBITS-1:0]           s_win_height,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tuser,
    input  logic [C_PIXEL_WIDTH-1:0]         s_axis_tdata,
    output logic                             s_axis_tready,
    output logic                             m_axis_need,
    output logic                             m_axis_valid,
    output logic [C_PIXEL_WIDTH-1:0]         m_axis_tdata,
    output logic                             m_axis_tuser,
    input  logic                             m_axis_next,
    output logic [$clog2(C_FIFO_DEPTH):0]    fifo_count,
    output logic                             underflow
);

    localparam int PTR_W = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(C_FIFO_DEPTH);

    logic [C_IMG_WBITS-1:0]   win_left;
    logic [C_IMG_WBITS-1:0]   win_width;
    logic [C_IMG_HBITS-1:0]   win_top;
    logic [C_IMG_HBITS-1:0]   win_height;

    logic [C_PIXEL_WIDTH:0]   mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic [C_IMG_WBITS:0]     col_end;
    logic [C_IMG_HBITS:0]     row_end;
    logic                     push;
    logic                     pop;
    logic [C_PIXEL_WIDTH:0]   head;

    // One extra bit on the end bounds keeps a window touching the top of the
    // index range from wrapping; a zero extent makes the range empty.
    assign col_end = {1'b0, win_left} + {1'b0, win_width};
    assign row_end = {1'b0, win_top}  + {1'b0, win_height};

    assign m_axis_need = (col_idx >= win_left) && ({1'b0, col_idx} < col_end) &&
                         (row_idx >= win_top)  && ({1'b0, row_idx} < row_end);

    assign m_axis_valid  = (count != '0);
    assign pop           = m_axis_need && m_axis_next && m_axis_valid;
    assign s_axis_tready = !reset && (frame_start || (count < DEPTH_CNT) || pop);
    assign push          = s_axis_tvalid && s_axis_tready;

    assign head         = mem[rd_ptr];
    assign m_axis_tdata = m_axis_valid ? head[C_PIXEL_WIDTH-1:0] : '0;
    assign m_axis_tuser = m_axis_valid ? head[C_PIXEL_WIDTH] : 1'b0;
    assign fifo_count   = count;

    // A flush restarts the ring at slot 0, so a same-cycle push lands there.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[frame_start ? '0 : wr_ptr] <= {s_axis_tuser, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            win_left   <= s_win_left;
            win_width  <= s_win_width;
            win_top    <= s_win_top;
            win_height <= s_win_height;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            rd_ptr    <= '0;
            wr_ptr    <= push ? PTR_W'(1) : '0;
            count     <= push ? CNT_W'(1) : '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (m_axis_need && m_axis_next && !m_axis_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_window_shifter.sv
`default_nettype none
// ============================================================================
// tb_axis_window_shifter : directed bench with a queue-based reference model
// Revision 1.0 - initial release
// ============================================================================
module tb_axis_window_shifter;

    localparam int PW = 8;
    localparam int WB = 12;
    localparam int HB = 12;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [WB-1:0] col_idx;
    logic [HB-1:0] row_idx;
    logic [WB-1:0] s_win_left;
    logic [WB-1:0] s_win_width;
    logic [HB-1:0] s_win_top;
    logic [HB-1:0] s_win_height;
    logic          s_axis_tvalid;
    logic          s_axis_tuser;
    logic [PW-1:0] s_axis_tdata;
    logic          s_axis_tready;
    logic          m_axis_need;
    logic          m_axis_valid;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_next;
    logic [2:0]    fifo_count;
    logic          underflow;

    always #5 clk = ~clk;

    axis_window_shifter #(
        .C_PIXEL_WIDTH (PW),
        .C_IMG_WBITS   (WB),
        .C_IMG_HBITS   (HB),
        .C_FIFO_DEPTH  (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .col_idx       (col_idx),
        .row_idx       (row_idx),
        .s_win_left    (s_win_left),
        .s_win_width   (s_win_width),
        .s_win_top     (s_win_top),
        .s_win_height  (s_win_height),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_need   (m_axis_need),
        .m_axis_valid  (m_axis_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_next   (m_axis_next),
        .fifo_count    (fifo_count),
        .underflow     (underflow)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow window as integers, buffer as a queue of {tuser,tdata}.
    int         sl, sw, st, sh;
    logic [8:0] q[$];
    bit         muf = 1'b0;

    function automatic bit m_need();
        return (int'(col_idx) >= sl) && (int'(col_idx) < sl + sw) &&
               (int'(row_idx) >= st) && (int'(row_idx) < st + sh);
    endfunction

    function automatic bit m_tready();
        return !reset && (frame_start || q.size() < D ||
                          (m_need() && m_axis_next && q.size() > 0));
    endfunction

    always @(posedge clk) begin : model_upd
        bit nd, pu, po;
        nd = m_need();
        pu = s_axis_tvalid && m_tready();
        po = nd && m_axis_next && (q.size() > 0);
        if (reset || frame_start) begin
            sl = int'(s_win_left);  sw = int'(s_win_width);
            st = int'(s_win_top);   sh = int'(s_win_height);
        end
        if (reset) begin
            q.delete();
            muf = 1'b0;
        end else if (frame_start) begin
            q.delete();
            if (pu) q.push_back({s_axis_tuser, s_axis_tdata});
            muf = 1'b0;
        end else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back({s_axis_tuser, s_axis_tdata});
            if (nd && m_axis_next && (q.size() == 0) && !po) muf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("need",   32'(m_axis_need),   32'(m_need()));
            check("tready", 32'(s_axis_tready), 32'(m_tready()));
            check("valid",  32'(m_axis_valid),  32'(q.size() != 0));
            check("count",  32'(fifo_count),    32'(q.size()));
            check("tdata",  32'(m_axis_tdata),  (q.size() != 0) ? 32'(q[0][7:0]) : 32'd0);
            check("tuser",  32'(m_axis_tuser),  (q.size() != 0) ? 32'(q[0][8]) : 32'd0);
            check("uflow",  32'(underflow),     32'(muf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_win(input int l, input int w, input int t, input int h);
        s_win_left = WB'(l); s_win_width = WB'(w);
        s_win_top  = HB'(t); s_win_height = HB'(h);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; col_idx = '0; row_idx = '0;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = '0; m_axis_next = 1'b0;
        set_win(2, 3, 1, 2);
        tick(); tick();
        checking = 1'b1;
        check("rst_count",  32'(fifo_count),    32'd0);
        check("rst_valid",  32'(m_axis_valid),  32'd0);
        check("rst_uflow",  32'(underflow),     32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tdata",  32'(m_axis_tdata),  32'd0);
        reset = 1'b0;
        tick();

        // Window hit sweep: (2,1,3,2) covers cols 2..4, rows 1..2
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                col_idx = WB'(c); row_idx = HB'(r);
                #1;
                check("need_sweep", 32'(m_axis_need), 32'(c >= 2 && c <= 4 && r >= 1 && r <= 2));
                tick();
            end
        end

        // Shadowing: live left change is ignored until frame_start
        col_idx = 12'd5; row_idx = 12'd1;
        #1; check("shadow_before", 32'(m_axis_need), 32'd0);
        s_win_left = 12'd5;
        tick(); check("shadow_mid", 32'(m_axis_need), 32'd0);
        pulse_frame();
        #1; check("shadow_after", 32'(m_axis_need), 32'd1);

        // Fill to full, then full with simultaneous pop accepts
        set_win(0, 16, 0, 16);
        pulse_frame();
        col_idx = '0; row_idx = '0;
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tuser = (i == 0); s_axis_tdata = PW'(8'h11 + i);
            tick();
        end
        s_axis_tdata = 8'h15; s_axis_tuser = 1'b0;
        #1;
        check("full_tready", 32'(s_axis_tready), 32'd0);
        check("full_count",  32'(fifo_count),    32'd4);
        check("full_head",   32'(m_axis_tdata),  32'h11);
        check("full_tuser",  32'(m_axis_tuser),  32'd1);
        m_axis_next = 1'b1;
        #1; check("full_pop_tready", 32'(s_axis_tready), 32'd1);
        tick();
        s_axis_tvalid = 1'b0; m_axis_next = 1'b0;
        #1;
        check("full_pop_count", 32'(fifo_count),   32'd4);
        check("full_pop_head",  32'(m_axis_tdata), 32'h12);

        // Drain exactly four entries
        m_axis_next = 1'b1;
        repeat (4) tick();
        m_axis_next = 1'b0;
        #1; check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_uflow", 32'(underflow), 32'd0);

        // Underflow sticky, cleared by frame_start
        m_axis_next = 1'b1; tick(); m_axis_next = 1'b0;
        #1; check("uflow_set", 32'(underflow), 32'd1);
        tick(); check("uflow_hold", 32'(underflow), 32'd1);
        pulse_frame();
        #1; check("uflow_clear", 32'(underflow), 32'd0);

        // frame_start wins over a simultaneous underflow condition
        frame_start = 1'b1; m_axis_next = 1'b1; tick();
        frame_start = 1'b0; m_axis_next = 1'b0;
        #1; check("uflow_prio", 32'(underflow), 32'd0);

        // Latency one: push A5, visible next cycle
        #1; check("lat_empty", 32'(m_axis_valid), 32'd0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; tick();
        s_axis_tvalid = 1'b0;
        #1;
        check("lat_valid", 32'(m_axis_valid), 32'd1);
        check("lat_tdata", 32'(m_axis_tdata), 32'hA5);

        // Flush with simultaneous push and pop
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h31; tick();
        s_axis_tdata = 8'h32; tick();
        s_axis_tvalid = 1'b0;
        #1; check("flush_pre", 32'(fifo_count), 32'd3);
        frame_start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h7E; s_axis_tuser = 1'b1;
        m_axis_next = 1'b1;
        #1; check("flush_tready", 32'(s_axis_tready), 32'd1);
        tick();
        frame_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; m_axis_next = 1'b0;
        #1;
        check("flush_count", 32'(fifo_count),   32'd1);
        check("flush_tdata", 32'(m_axis_tdata), 32'h7E);
        check("flush_tuser", 32'(m_axis_tuser), 32'd1);

        // Reset mid-stream overrides frame_start and push
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h44; tick(); tick();
        reset = 1'b1; frame_start = 1'b1;
        #1; check("rst_mid_tready", 32'(s_axis_tready), 32'd0);
        tick();
        reset = 1'b0; frame_start = 1'b0; s_axis_tvalid = 1'b0;
        #1;
        check("rst_mid_count", 32'(fifo_count),   32'd0);
        check("rst_mid_valid", 32'(m_axis_valid), 32'd0);

        // Zero-width window never needs a pixel
        s_win_width = '0;
        pulse_frame();
        m_axis_next = 1'b1;
        #1; check("zero_w_need", 32'(m_axis_need), 32'd0);
        tick(); m_axis_next = 1'b0;
        #1; check("zero_w_uflow", 32'(underflow), 32'd0);

        // Mixed push/pop traffic exercises pointer wrap
        s_win_width = 12'd16;
        pulse_frame();
        for (int i = 0; i < 64; i++) begin
            s_axis_tvalid = (i % 3) != 0;
            s_axis_tuser  = (i % 5) == 0;
            s_axis_tdata  = PW'(i * 7 + 3);
            m_axis_next   = (i % 4) < 2;
            tick();
        end
        s_axis_tvalid = 1'b0; m_axis_next = 1'b0;
        tick(); tick();

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
